// File: rtl/ram_dp_be_pipe.sv
// True dual-port byte-writable RAM with 1- or 2-cycle registered reads, selectable same-port
// read-during-write behaviour and a registered write/write collision flag.
module ram_dp_be_pipe #(
  parameter int unsigned DWIDTH            = 32,
  parameter int unsigned NBYTES            = DWIDTH / 8,
  parameter int unsigned AWIDTH            = 10,
  parameter int unsigned DEPTH             = 1024,
  parameter int unsigned LATENCY           = 1,
  parameter int unsigned RD_MODE           = 0,
  parameter string       MEM_INIT_HEX_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en0_i,
  input  logic [NBYTES-1:0] we0_i,
  input  logic [AWIDTH-1:0] addr0_i,
  input  logic [DWIDTH-1:0] d0_i,
  output logic [DWIDTH-1:0] q0_o,
  output logic              qv0_o,
  input  logic              en1_i,
  input  logic [NBYTES-1:0] we1_i,
  input  logic [AWIDTH-1:0] addr1_i,
  input  logic [DWIDTH-1:0] d1_i,
  output logic [DWIDTH-1:0] q1_o,
  output logic              qv1_o,
  output logic              coll_o
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic              en      [2];
  logic [NBYTES-1:0] we      [2];
  logic [AWIDTH-1:0] addr    [2];
  logic [DWIDTH-1:0] wd      [2];
  logic [DWIDTH-1:0] rd_data [2];
  logic [1:0]        act;
  logic [1:0]        in_rng;
  logic [1:0]        rd_vld;

  assign en[0]   = en0_i;
  assign en[1]   = en1_i;
  assign we[0]   = we0_i;
  assign we[1]   = we1_i;
  assign addr[0] = addr0_i;
  assign addr[1] = addr1_i;
  assign wd[0]   = d0_i;
  assign wd[1]   = d1_i;

  // Read value sampled at the edge: pre-write word, optionally merged with this port's own bytes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      act[p]     = en[p] & ~rst;
      in_rng[p]  = 32'(addr[p]) < DEPTH;
      rd_data[p] = '0;
      if (in_rng[p]) begin
        rd_data[p] = mem_q[addr[p][IdxW-1:0]];
        if (RD_MODE == 1) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (we[p][b]) rd_data[p][8*b +: 8] = wd[p][8*b +: 8];
          end
        end
      end
      rd_vld[p] = act[p] && !(RD_MODE == 2 && we[p] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      // Port 0 is applied last so it wins overlapping bytes on a same-address collision.
      if (act[1] && in_rng[1] && we[1][b]) mem_q[addr[1][IdxW-1:0]][8*b +: 8] <= wd[1][8*b +: 8];
      if (act[0] && in_rng[0] && we[0][b]) mem_q[addr[0][IdxW-1:0]][8*b +: 8] <= wd[0][8*b +: 8];
    end
  end

  logic [1:0]        s1_vld_q;
  logic [DWIDTH-1:0] s1_data_q [2];
  logic              coll_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= '0;
      s1_data_q[0] <= '0;
      s1_data_q[1] <= '0;
      coll_q       <= 1'b0;
    end else begin
      s1_vld_q <= rd_vld;
      for (int p = 0; p < 2; p++) begin
        if (rd_vld[p]) s1_data_q[p] <= rd_data[p];
      end
      coll_q <= act[0] && act[1] && (addr[0] == addr[1]) && ((we[0] & we[1]) != '0);
    end
  end

  logic [1:0]        out_vld;
  logic [DWIDTH-1:0] out_data [2];

  if (LATENCY == 2) begin : g_lat2
    logic [1:0]        s2_vld_q;
    logic [DWIDTH-1:0] s2_data_q [2];

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld_q     <= '0;
        s2_data_q[0] <= '0;
        s2_data_q[1] <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        for (int p = 0; p < 2; p++) begin
          if (s1_vld_q[p]) s2_data_q[p] <= s1_data_q[p];
        end
      end
    end

    assign out_vld  = s2_vld_q;
    assign out_data = s2_data_q;
  end else begin : g_lat1
    assign out_vld  = s1_vld_q;
    assign out_data = s1_data_q;
  end

  assign q0_o   = out_data[0];
  assign q1_o   = out_data[1];
  assign qv0_o  = out_vld[0];
  assign qv1_o  = out_vld[1];
  assign coll_o = coll_q;

endmodule

// File: tb/tb_ram_dp_be_pipe.sv
// Bench for ram_dp_be_pipe: three instances (L1/read-first, L2/write-first, L1/no-change)
// share stimulus and are compared every cycle against a word-array reference model.
module tb_ram_dp_be_pipe;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en0, en1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] q0 [3];
  logic [DW-1:0] q1 [3];
  logic          qv0 [3];
  logic          qv1 [3];
  logic          coll [3];

  ram_dp_be_pipe #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .LATENCY(1), .RD_MODE(0)) u_m0 (
    .clk(clk), .rst(rst),
    .en0_i(en0), .we0_i(we0), .addr0_i(a0), .d0_i(d0), .q0_o(q0[0]), .qv0_o(qv0[0]),
    .en1_i(en1), .we1_i(we1), .addr1_i(a1), .d1_i(d1), .q1_o(q1[0]), .qv1_o(qv1[0]),
    .coll_o(coll[0])
  );
  ram_dp_be_pipe #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .LATENCY(2), .RD_MODE(1)) u_m1 (
    .clk(clk), .rst(rst),
    .en0_i(en0), .we0_i(we0), .addr0_i(a0), .d0_i(d0), .q0_o(q0[1]), .qv0_o(qv0[1]),
    .en1_i(en1), .we1_i(we1), .addr1_i(a1), .d1_i(d1), .q1_o(q1[1]), .qv1_o(qv1[1]),
    .coll_o(coll[1])
  );
  ram_dp_be_pipe #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .LATENCY(1), .RD_MODE(2)) u_m2 (
    .clk(clk), .rst(rst),
    .en0_i(en0), .we0_i(we0), .addr0_i(a0), .d0_i(d0), .q0_o(q0[2]), .qv0_o(qv0[2]),
    .en1_i(en1), .we1_i(we1), .addr1_i(a1), .d1_i(d1), .q1_o(q1[2]), .qv1_o(qv1[2]),
    .coll_o(coll[2])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: plain word array plus expected output state per instance/port.
  logic [31:0] mmem [DEPTH];
  logic [31:0] eq    [3][2];
  bit          ev    [3][2];
  bit          st1_v [3][2];
  logic [31:0] st1_d [3][2];
  bit          ecoll;

  function automatic int lat_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  task automatic model_edge();
    bit          pe [2];
    logic [3:0]  pw [2];
    int          pa [2];
    logic [31:0] pd [2];
    logic [31:0] val;
    bit          rv;
    pe[0] = en0; pw[0] = we0; pa[0] = int'(a0); pd[0] = d0;
    pe[1] = en1; pw[1] = we1; pa[1] = int'(a1); pd[1] = d1;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int p = 0; p < 2; p++) begin
          eq[i][p] = '0; ev[i][p] = 0; st1_v[i][p] = 0; st1_d[i][p] = '0;
        end
      end
      ecoll = 0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        val = (pa[p] < DEPTH) ? mmem[pa[p]] : 32'h0;
        if (i == 1 && pa[p] < DEPTH) begin
          for (int b = 0; b < 4; b++) if (pw[p][b]) val[8*b +: 8] = pd[p][8*b +: 8];
        end
        rv = pe[p] && !(i == 2 && pw[p] != 4'h0);
        if (lat_of(i) == 1) begin
          ev[i][p] = rv;
          if (rv) eq[i][p] = val;
        end else begin
          ev[i][p] = st1_v[i][p];
          if (st1_v[i][p]) eq[i][p] = st1_d[i][p];
          st1_v[i][p] = rv;
          if (rv) st1_d[i][p] = val;
        end
      end
    end
    ecoll = pe[0] && pe[1] && pa[0] == pa[1] && (pw[0] & pw[1]) != 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (pe[1] && pa[1] < DEPTH && pw[1][b]) mmem[pa[1]][8*b +: 8] = pd[1][8*b +: 8];
      if (pe[0] && pa[0] < DEPTH && pw[0][b]) mmem[pa[0]][8*b +: 8] = pd[0][8*b +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m%0d.q0", i), q0[i], eq[i][0]);
      chk($sformatf("m%0d.qv0", i), 32'(qv0[i]), 32'(ev[i][0]));
      chk($sformatf("m%0d.q1", i), q1[i], eq[i][1]);
      chk($sformatf("m%0d.qv1", i), 32'(qv1[i]), 32'(ev[i][1]));
      chk($sformatf("m%0d.coll", i), 32'(coll[i]), 32'(ecoll));
    end
  endtask

  task automatic idle();
    en0 = 0; we0 = '0; en1 = 0; we1 = '0;
  endtask

  typedef struct {
    logic          rst;
    logic          en0;
    logic [3:0]    we0;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic          en1;
    logic [3:0]    we1;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
    logic [31:0]   eq0;
    logic          eqv0;
    logic [31:0]   eq1;
    logic          eqv1;
    logic          ecoll;
  } vec_t;

  vec_t vt [16];
  bit   exp_v;

  initial begin
    // Expected outputs of the LATENCY=1 read-first instance after each edge.
    vt[0]  = '{0, 1, 4'hF, 3,  32'h11223344, 0, 4'h0, 0,  32'h0,
               32'h0,        1, 32'h0,        0, 0};
    vt[1]  = '{0, 1, 4'h5, 3,  32'hAABBCCDD, 0, 4'h0, 0,  32'h0,
               32'h11223344, 1, 32'h0,        0, 0};
    vt[2]  = '{0, 1, 4'h0, 3,  32'h0,        0, 4'h0, 0,  32'h0,
               32'h11BB33DD, 1, 32'h0,        0, 0};
    vt[3]  = '{0, 0, 4'h0, 0,  32'h0,        1, 4'hF, 4,  32'h11223344,
               32'h11BB33DD, 0, 32'h0,        1, 0};
    vt[4]  = '{0, 0, 4'h0, 0,  32'h0,        1, 4'h5, 4,  32'hAABBCCDD,
               32'h11BB33DD, 0, 32'h11223344, 1, 0};
    vt[5]  = '{0, 0, 4'h0, 0,  32'h0,        1, 4'h0, 4,  32'h0,
               32'h11BB33DD, 0, 32'h11BB33DD, 1, 0};
    vt[6]  = '{0, 1, 4'hF, 2,  32'h1,        0, 4'h0, 0,  32'h0,
               32'h0,        1, 32'h11BB33DD, 0, 0};
    vt[7]  = '{0, 1, 4'hF, 2,  32'h2,        1, 4'h0, 2,  32'h0,
               32'h1,        1, 32'h1,        1, 0};
    vt[8]  = '{0, 0, 4'h0, 0,  32'h0,        1, 4'h0, 2,  32'h0,
               32'h1,        0, 32'h2,        1, 0};
    vt[9]  = '{0, 1, 4'h3, 7,  32'hAAAAAAAA, 1, 4'h6, 7,  32'hBBBBBBBB,
               32'h0,        1, 32'h0,        1, 1};
    vt[10] = '{0, 1, 4'h0, 7,  32'h0,        0, 4'h0, 0,  32'h0,
               32'h00BBAAAA, 1, 32'h0,        0, 0};
    vt[11] = '{0, 1, 4'hF, 50, 32'hFFFFFFFF, 1, 4'h0, 50, 32'h0,
               32'h0,        1, 32'h0,        1, 0};
    vt[12] = '{0, 1, 4'h0, 18, 32'h0,        0, 4'h0, 0,  32'h0,
               32'h0,        1, 32'h0,        0, 0};
    vt[13] = '{1, 1, 4'h0, 7,  32'h0,        1, 4'hF, 3,  32'h0,
               32'h0,        0, 32'h0,        0, 0};
    vt[14] = '{0, 0, 4'h0, 0,  32'h0,        0, 4'h0, 0,  32'h0,
               32'h0,        0, 32'h0,        0, 0};
    vt[15] = '{0, 1, 4'h0, 3,  32'h0,        1, 4'h0, 4,  32'h0,
               32'h11BB33DD, 1, 32'h11BB33DD, 1, 0};

    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    rst = 1; idle(); a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.m%0d.q0", i), q0[i], 32'h0);
      chk($sformatf("rst.m%0d.qv", i), {30'h0, qv1[i], qv0[i]}, 32'h0);
      chk($sformatf("rst.m%0d.coll", i), 32'(coll[i]), 32'h0);
    end
    rst = 0;

    for (int k = 0; k < 16; k++) begin
      rst = vt[k].rst;
      en0 = vt[k].en0; we0 = vt[k].we0; a0 = vt[k].a0; d0 = vt[k].d0;
      en1 = vt[k].en1; we1 = vt[k].we1; a1 = vt[k].a1; d1 = vt[k].d1;
      step();
      chk($sformatf("vec%0d.q0", k), q0[0], vt[k].eq0);
      chk($sformatf("vec%0d.qv0", k), 32'(qv0[0]), 32'(vt[k].eqv0));
      chk($sformatf("vec%0d.q1", k), q1[0], vt[k].eq1);
      chk($sformatf("vec%0d.qv1", k), 32'(qv1[0]), 32'(vt[k].eqv1));
      chk($sformatf("vec%0d.coll", k), 32'(coll[0]), 32'(vt[k].ecoll));
    end
    rst = 0; idle();

    // Memory survives reset; reads under reset never pulse qv.
    en0 = 1; we0 = 4'hF; a0 = 5; d0 = 32'hDEADBEEF; step();
    rst = 1; we0 = 4'h0;
    repeat (2) begin
      step();
      for (int i = 0; i < 3; i++) chk($sformatf("rstq.m%0d.qv0", i), 32'(qv0[i]), 32'h0);
    end
    rst = 0; step();
    chk("rstkeep.m0", q0[0], 32'hDEADBEEF);
    idle(); step();
    chk("rstkeep.m1", q0[1], 32'hDEADBEEF);

    // LATENCY=2 back-to-back streaming of a preloaded region.
    for (int k = 0; k < 4; k++) begin
      en0 = 1; we0 = 4'hF; a0 = AW'(2 * k);     d0 = 32'(6 * k);
      en1 = 1; we1 = 4'hF; a1 = AW'(2 * k + 1); d1 = 32'(6 * k + 3);
      step();
    end
    idle(); repeat (2) step();
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        en0 = 1; we0 = 4'h0; a0 = AW'(c);
      end else begin
        en0 = 0;
      end
      step();
      exp_v = (c >= 1 && c <= 8);
      chk($sformatf("stream%0d.qv", c), 32'(qv0[1]), 32'(exp_v));
      if (exp_v) chk($sformatf("stream%0d.q", c), q0[1], 32'(3 * (c - 1)));
    end

    // Same-port read-during-write in all three modes.
    idle(); en1 = 1; we1 = 4'hF; a1 = 9; d1 = 32'h0000FFFF; step();
    idle(); en0 = 1; a0 = 9; step();
    we0 = 4'h3; d0 = 32'h12345678; step();
    chk("rdw.m0.q", q0[0], 32'h0000FFFF);
    chk("rdw.m0.qv", 32'(qv0[0]), 32'h1);
    chk("rdw.m2.q", q0[2], 32'h0000FFFF);
    chk("rdw.m2.qv", 32'(qv0[2]), 32'h0);
    idle(); step();
    chk("rdw.m1.q", q0[1], 32'h00005678);
    chk("rdw.m1.qv", 32'(qv0[1]), 32'h1);
    en0 = 1; a0 = 9; step();
    chk("rdw.after.m0", q0[0], 32'h00005678);
    chk("rdw.after.m2", q0[2], 32'h00005678);
    idle(); step();
    chk("rdw.after.m1", q0[1], 32'h00005678);

    // Random traffic, biased towards shared addresses and occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      we0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      we1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      a0  = AW'($urandom_range(0, 55));
      a1  = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, 55));
      d0  = $urandom;
      d1  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
